// File: rtl/toast_dmem_if.sv
// toast_dmem_if: bundles the two access ports of the data memory.
//   Port A (pipeline): DMEM_addr_i, DMEM_wr_byte_en_i, DMEM_wr_data_i,
//                      DMEM_rst_i -> DMEM_rd_data_o (one-cycle registered read)
//   Port B (debug/loader): DBG_req_i, DBG_we_i, DBG_addr_i, DBG_wr_data_i
//                      -> DBG_ack_o (one-cycle pulse), DBG_rd_data_o
// Modports: master = requester side (MEM stage / loader), slave = memory.
interface toast_dmem_if;
  logic [31:0] DMEM_addr_i;
  logic [3:0]  DMEM_wr_byte_en_i;
  logic [31:0] DMEM_wr_data_i;
  logic        DMEM_rst_i;
  logic [31:0] DMEM_rd_data_o;

  logic        DBG_req_i;
  logic        DBG_we_i;
  logic [31:0] DBG_addr_i;
  logic [31:0] DBG_wr_data_i;
  logic        DBG_ack_o;
  logic [31:0] DBG_rd_data_o;

  modport master (
    output DMEM_addr_i, DMEM_wr_byte_en_i, DMEM_wr_data_i, DMEM_rst_i,
    input  DMEM_rd_data_o,
    output DBG_req_i, DBG_we_i, DBG_addr_i, DBG_wr_data_i,
    input  DBG_ack_o, DBG_rd_data_o
  );

  modport slave (
    input  DMEM_addr_i, DMEM_wr_byte_en_i, DMEM_wr_data_i, DMEM_rst_i,
    output DMEM_rd_data_o,
    input  DBG_req_i, DBG_we_i, DBG_addr_i, DBG_wr_data_i,
    output DBG_ack_o, DBG_rd_data_o
  );
endinterface

// File: rtl/toast_dmem.sv
// toast_dmem: byte-addressable data memory, sole owner of data storage.
// Ports:
//   clk_i     - single clock, rising edge
//   resetn_i  - synchronous active-low reset (does not clear the array)
//   bus       - toast_dmem_if.slave:
//                 port A: read every cycle, per-lane writes, registered read
//                 data with one-cycle latency, read-first, DMEM_rst_i clears
//                 the read register only.
//                 port B: req/ack debug port, IDLE -> ACCESS -> DONE; a port B
//                 write colliding with a port A write to the same word waits.
// Parameters:
//   DEPTH_WORDS - number of 32-bit words, power of two, >= 4. Address bits
//                 above the index are ignored, so the memory aliases.
module toast_dmem #(
  parameter int unsigned DEPTH_WORDS = 32'd1024
) (
  input logic         clk_i,
  input logic         resetn_i,
  toast_dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dbg_state_e;

  logic [31:0]   mem_r [DEPTH_WORDS];

  logic [AW-1:0] a_idx_s;
  logic [AW-1:0] b_idx_s;
  logic [31:0]   rd_a_r;

  dbg_state_e    state_r;
  dbg_state_e    state_nx_s;
  logic          dbg_we_r;
  logic [AW-1:0] dbg_idx_r;
  logic [31:0]   dbg_data_r;
  logic [31:0]   dbg_rd_r;
  logic          dbg_ack_s;
  logic          collision_s;
  logic          b_write_s;

  assign a_idx_s = bus.DMEM_addr_i[AW+1:2];
  assign b_idx_s = bus.DBG_addr_i[AW+1:2];

  // Collision and port B write-commit decode.
  always_comb begin
    collision_s = 1'b0;
    b_write_s   = 1'b0;
    if (dbg_we_r && (dbg_idx_r == a_idx_s) && (bus.DMEM_wr_byte_en_i != 4'b0000)) begin
      collision_s = 1'b1;
    end else begin
      collision_s = 1'b0;
    end
    // A port B write in the same cycle as reset is dropped, not committed.
    if ((state_r == ST_ACCESS) && dbg_we_r && !collision_s && resetn_i) begin
      b_write_s = 1'b1;
    end else begin
      b_write_s = 1'b0;
    end
  end

  // Storage array: port A lane writes and port B full-word writes. The
  // collision rule guarantees both never target the same word in one cycle.
  // Port A writes commit regardless of reset or DMEM_rst_i.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.DMEM_wr_byte_en_i[k]) begin
        mem_r[a_idx_s][8*k +: 8] <= bus.DMEM_wr_data_i[8*k +: 8];
      end
    end
    if (b_write_s) begin
      mem_r[dbg_idx_r] <= dbg_data_r;
    end
  end

  // Port A registered read (read-first); reset or DMEM_rst_i override it.
  always_ff @(posedge clk_i) begin
    if (!resetn_i || bus.DMEM_rst_i) begin
      rd_a_r <= 32'd0;
    end else begin
      rd_a_r <= mem_r[a_idx_s];
    end
  end

  // Port B FSM state register.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Port B FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.DBG_req_i) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (collision_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Port B FSM outputs: ack is decoded straight from the state register.
  always_comb begin
    dbg_ack_s = 1'b0;
    case (state_r)
      ST_DONE: dbg_ack_s = 1'b1;
      default: dbg_ack_s = 1'b0;
    endcase
  end

  // Port B request latch, captured when a request is accepted in IDLE.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      dbg_we_r   <= 1'b0;
      dbg_idx_r  <= '0;
      dbg_data_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && bus.DBG_req_i) begin
      dbg_we_r   <= bus.DBG_we_i;
      dbg_idx_r  <= b_idx_s;
      dbg_data_r <= bus.DBG_wr_data_i;
    end
  end

  // Port B read data: captured on the ACCESS edge of a read, held otherwise.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      dbg_rd_r <= 32'd0;
    end else if ((state_r == ST_ACCESS) && !dbg_we_r) begin
      dbg_rd_r <= mem_r[dbg_idx_r];
    end
  end

  assign bus.DMEM_rd_data_o = rd_a_r;
  assign bus.DBG_rd_data_o  = dbg_rd_r;
  assign bus.DBG_ack_o      = dbg_ack_s;

endmodule

// File: tb/tb_toast_dmem.sv
// tb_toast_dmem: self-checking bench for toast_dmem. Expected port A and
// port B read data are pushed to queues when stimulus is driven and popped
// when the DUT presents its output.
module tb_toast_dmem;

  logic clk_i;
  logic resetn_i;

  toast_dmem_if bus ();

  toast_dmem #(.DEPTH_WORDS(32'd1024)) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [1024];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] dbg_rd_m;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] addr);
    return (addr >> 2) & 32'd1023;
  endfunction

  // One port A cycle: drive, predict, clock, compare.
  task automatic a_cycle(input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data, input logic drst);
    int unsigned idx;
    idx = idx_of(addr);
    bus.DMEM_addr_i       = addr;
    bus.DMEM_wr_byte_en_i = be;
    bus.DMEM_wr_data_i    = data;
    bus.DMEM_rst_i        = drst;
    if (drst || !resetn_i) qa.push_back(32'd0);
    else                   qa.push_back(mem_m[idx]);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mem_m[idx][8*k +: 8] = data[8*k +: 8];
    end
    @(posedge clk_i);
    #1;
    check_eq("portA_rd", bus.DMEM_rd_data_o, qa.pop_front());
    bus.DMEM_wr_byte_en_i = 4'b0000;
    bus.DMEM_rst_i        = 1'b0;
  endtask

  // One port B transaction with bounded wait for ack.
  task automatic dbg_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_lat);
    int  lat;
    bit  got;
    int unsigned idx;
    idx = idx_of(addr);
    bus.DMEM_wr_byte_en_i = 4'b0000;
    bus.DBG_req_i     = 1'b1;
    bus.DBG_we_i      = we;
    bus.DBG_addr_i    = addr;
    bus.DBG_wr_data_i = data;
    if (!we) qb.push_back(mem_m[idx]);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (bus.DBG_ack_o) got = 1'b1;
    end
    bus.DBG_req_i = 1'b0;
    check_eq("dbg_ack_latency", 32'(lat), 32'(exp_lat));
    if (we) begin
      mem_m[idx] = data;
      check_eq("dbg_rd_hold", bus.DBG_rd_data_o, dbg_rd_m);
    end else begin
      if (qb.size() > 0) dbg_rd_m = qb.pop_front();
      check_eq("dbg_rd", bus.DBG_rd_data_o, dbg_rd_m);
    end
    @(posedge clk_i);
    #1;
    check_eq("dbg_ack_pulse", 32'(bus.DBG_ack_o), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  got;

    resetn_i              = 1'b0;
    bus.DMEM_addr_i       = 32'd0;
    bus.DMEM_wr_byte_en_i = 4'b0000;
    bus.DMEM_wr_data_i    = 32'd0;
    bus.DMEM_rst_i        = 1'b0;
    bus.DBG_req_i         = 1'b0;
    bus.DBG_we_i          = 1'b0;
    bus.DBG_addr_i        = 32'd0;
    bus.DBG_wr_data_i     = 32'd0;
    dbg_rd_m              = 32'd0;

    // Reset state.
    a_cycle(32'h0, 4'b0000, 32'h0, 1'b0);
    a_cycle(32'h0, 4'b0000, 32'h0, 1'b0);
    check_eq("rst_ack", 32'(bus.DBG_ack_o), 32'd0);
    check_eq("rst_dbg_rd", bus.DBG_rd_data_o, 32'd0);
    resetn_i = 1'b1;

    // Port A single word.
    a_cycle(32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
    a_cycle(32'h10, 4'b0000, 32'h0, 1'b0);

    // Byte lanes.
    a_cycle(32'h20, 4'b1111, 32'h11223344, 1'b0);
    a_cycle(32'h20, 4'b0100, 32'h00AA0000, 1'b0);
    a_cycle(32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0);
    a_cycle(32'h20, 4'b0000, 32'h0, 1'b0);

    // Read-first and DMEM_rst_i.
    a_cycle(32'h30, 4'b1111, 32'h01020304, 1'b0);
    a_cycle(32'h30, 4'b1111, 32'h0A0B0C0D, 1'b0);
    a_cycle(32'h30, 4'b1111, 32'h55667788, 1'b1);
    a_cycle(32'h30, 4'b0000, 32'h0, 1'b0);

    // Port B load and readback.
    dbg_op(1'b1, 32'h40, 32'hCAFEF00D, 2);
    dbg_op(1'b0, 32'h40, 32'h0, 2);
    a_cycle(32'h40, 4'b0000, 32'h0, 1'b0);
    dbg_op(1'b0, 32'h20, 32'h0, 2);

    // Collision: port A writes 0x50 for three cycles while port B is in ACCESS.
    a_cycle(32'h50, 4'b1111, 32'h50505050, 1'b0);
    bus.DBG_req_i     = 1'b1;
    bus.DBG_we_i      = 1'b1;
    bus.DBG_addr_i    = 32'h50;
    bus.DBG_wr_data_i = 32'h5A5A0B0B;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      a_cycle(32'h50, (i >= 1 && i <= 3) ? 4'b1111 : 4'b0000, 32'hA0000000 + 32'(i), 1'b0);
      lat++;
      if (bus.DBG_ack_o) got = 1'b1;
    end
    bus.DBG_req_i = 1'b0;
    mem_m[idx_of(32'h50)] = 32'h5A5A0B0B;
    check_eq("collision_latency", 32'(lat), 32'd5);
    a_cycle(32'h50, 4'b0000, 32'h0, 1'b0);
    check_eq("collision_ack_drop", 32'(bus.DBG_ack_o), 32'd0);
    dbg_op(1'b0, 32'h50, 32'h0, 2);

    // Different words written by both ports in the same cycle.
    bus.DBG_req_i     = 1'b1;
    bus.DBG_we_i      = 1'b1;
    bus.DBG_addr_i    = 32'h70;
    bus.DBG_wr_data_i = 32'h77777777;
    a_cycle(32'h74, 4'b0000, 32'h0, 1'b0);
    a_cycle(32'h74, 4'b1111, 32'h74747474, 1'b0);
    bus.DBG_req_i = 1'b0;
    mem_m[idx_of(32'h70)] = 32'h77777777;
    check_eq("dual_write_ack", 32'(bus.DBG_ack_o), 32'd1);
    a_cycle(32'h70, 4'b0000, 32'h0, 1'b0);
    a_cycle(32'h74, 4'b0000, 32'h0, 1'b0);

    // Aliasing.
    a_cycle(32'h1000, 4'b1111, 32'hA11A5ED0, 1'b0);
    a_cycle(32'h0, 4'b0000, 32'h0, 1'b0);

    // Reset while port B is in ACCESS: write dropped, no ack.
    a_cycle(32'h60, 4'b1111, 32'h60606060, 1'b0);
    bus.DBG_req_i     = 1'b1;
    bus.DBG_we_i      = 1'b1;
    bus.DBG_addr_i    = 32'h60;
    bus.DBG_wr_data_i = 32'hBADBAD00;
    @(posedge clk_i);
    #1;
    resetn_i      = 1'b0;
    bus.DBG_req_i = 1'b0;
    a_cycle(32'h60, 4'b0000, 32'h0, 1'b0);
    dbg_rd_m = 32'd0;
    check_eq("rst_access_ack", 32'(bus.DBG_ack_o), 32'd0);
    check_eq("rst_access_dbg_rd", bus.DBG_rd_data_o, dbg_rd_m);
    resetn_i = 1'b1;
    a_cycle(32'h60, 4'b0000, 32'h0, 1'b0);
    check_eq("rst_access_ack_after", 32'(bus.DBG_ack_o), 32'd0);
    a_cycle(32'h60, 4'b0000, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toast_dmem.md
# toast_dmem

Byte-addressable data memory that answers the MEM stage's data-memory port. Port A is the pipeline port: word-aligned address, per-byte write enables, write data, read-port reset, and registered read data with one-cycle latency. Port B is a request/acknowledge debug/loader port used by the testbench and boot logic to preload and inspect memory. The block sits beside the MEM stage at the core top level and is the only owner of data storage.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4. AW = log2(DEPTH_WORDS).
- clk_i  in  1  single clock; all state updates on the rising edge
- resetn_i  in  1  reset, synchronous, active-low
- DMEM_addr_i  in  32  port A byte address; bits [1:0] ignored, word index = [AW+1:2], upper bits ignored (aliasing)
- DMEM_wr_byte_en_i  in  4  port A byte write enables; bit k writes byte lane k, bits [8k+7:8k]
- DMEM_wr_data_i  in  32  port A write data, already lane-aligned by the requester
- DMEM_rst_i  in  1  port A read-output reset, active-high
- DMEM_rd_data_o  out  32  port A registered read data
- DBG_req_i  in  1  port B request; held high until DBG_ack_o is seen
- DBG_we_i  in  1  port B 1 = full-word write, 0 = read
- DBG_addr_i  in  32  port B byte address, decoded like port A
- DBG_wr_data_i  in  32  port B write data
- DBG_ack_o  out  1  port B completion, one-cycle pulse
- DBG_rd_data_o  out  32  port B read data, valid while DBG_ack_o = 1; holds until the next ack

## Operation
- Storage: DEPTH_WORDS x 32 array. Reset does not clear contents.
- Port A reads every cycle. The word at the sampled index is registered into DMEM_rd_data_o. The read is read-first: in the cycle after a write to the same word, the output shows the pre-write value.
- Port A writes update only the lanes whose enable bit is 1. A byte enable of 4'b0000 means no write.
- DMEM_rd_data_o is cleared to 0 at any edge where resetn_i = 0 or DMEM_rst_i = 1. The clear overrides the read. A write presented in that same cycle still commits.
- Port B FSM has three states:
  - IDLE: DBG_ack_o = 0. If DBG_req_i = 1, latch addr, we and data, then go to ACCESS.
  - ACCESS: perform the latched access, then go to DONE.
    - Collision: a port B write whose word index equals port A's index while DMEM_wr_byte_en_i != 0 is not performed. The FSM stays in ACCESS and retries next cycle. Port A always wins.
    - Port B reads never stall. They are read-first, with the same rule as port A.
  - DONE: DBG_ack_o = 1 for exactly one cycle, then go to IDLE. The requester drops DBG_req_i in the DONE cycle. A req still high in the following IDLE cycle is a new request.
- Port B reads capture the array word into DBG_rd_data_o at the ACCESS edge. A port B write leaves DBG_rd_data_o unchanged.

## Timing
- Reset values: DMEM_rd_data_o = 0, DBG_rd_data_o = 0, DBG_ack_o = 0, FSM = IDLE.
- Port A read latency: address sampled at edge N, data valid after edge N, i.e. usable throughout cycle N+1. This matches the MEM stage's one-cycle load latency.
- Port A write: committed at the edge where the enables are sampled. It is visible to either port's read sampled at edge N+1 or later.
- Port B, no collision: req sampled at edge 0 -> ACCESS at edge 1 -> ack high in cycle 2. Each collision cycle adds one cycle to this path.
- Reset mid-operation (resetn_i = 0 in ACCESS or DONE): return to IDLE with ack 0. An uncommitted port B write is dropped.
- Same-word, same-cycle writes from both ports cannot occur, because of the collision rule. Writes to different words from both ports in the same cycle both commit.

## Test plan
- Port A SW: write 0xDEADBEEF, enables 1111, to addr 0x10; read 0x10 next cycle -> DMEM_rd_data_o = 0xDEADBEEF one cycle after the read address.
- Byte lanes: preload 0x11223344 at 0x20; write enables 0100 with data 0x00AA0000 -> readback 0x11AA3344. Enables 0000 leave the word unchanged.
- Read-first and reset: read and write addr 0x30 in the same cycle -> old value returned. DMEM_rst_i = 1 -> output 0 next cycle while the write still lands.
- Port B load/readback: write 0xCAFEF00D to 0x40 -> ack 2 cycles after req. Read 0x40 -> ack with DBG_rd_data_o = 0xCAFEF00D.
- Collision: port B write to 0x50 while port A writes 0x50 for 3 consecutive cycles -> ack delayed by 3 cycles, and the final word equals port B's data.
- Aliasing and reset: with DEPTH_WORDS = 1024, write at 0x1000 -> visible at 0x0. Assert resetn_i = 0 during ACCESS -> no ack, word unchanged, outputs 0.
